// File: rtl/unary_stream_pkg.sv
// ----------------------------------------------------------------------------
// unary_stream_pkg
// Shared types and helpers for the unary stream generator.
//   usg_state_t     : FSM encoding (IDLE waits for an operand, RUN emits bits)
//   usg_stream_len  : number of bits in one stream, 2^lenlog
//   usg_last_cnt    : counter value that marks the final bit of a stream
// ----------------------------------------------------------------------------
package unary_stream_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } usg_state_t;

   localparam int unsigned USG_DEF_INWD   = 32'd4;
   localparam int unsigned USG_DEF_LENLOG = 32'd4;

   function automatic int unsigned usg_stream_len(input int unsigned lenlog);
      return 32'd1 << lenlog;
   endfunction

   function automatic int unsigned usg_last_cnt(input int unsigned lenlog);
      return usg_stream_len(lenlog) - 32'd1;
   endfunction

endpackage

// File: rtl/unary_stream_gen.sv
// ----------------------------------------------------------------------------
// unary_stream_gen
// Converts a binary operand into a unary bitstream of 2^LENLOG bits, where
// each bit is (rng_val < operand). The attached RNG is stepped only when a
// bit is consumed, so a full-length stream walks exactly one RNG period.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (in_ready high only in IDLE)
//   in_data  [INWD]      operand
//   rng_en               step request to the RNG (one per transferred bit)
//   rng_val  [INWD]      current RNG value
//   out_valid/out_ready  bit handshake
//   bit_out              unary stream bit
//   last                 final bit of the stream
//
// Build option: UNARY_STREAM_GEN_BIPOLAR_EN -- treat in_data as two's
// complement and flip its MSB on latch (offset binary), giving a bipolar
// stream. Without it the operand is unsigned (unipolar stream).
// ----------------------------------------------------------------------------
module unary_stream_gen
   import unary_stream_pkg::*;
#(
   parameter int unsigned INWD   = USG_DEF_INWD,
   parameter int unsigned LENLOG = USG_DEF_LENLOG
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [INWD-1:0] in_data,
   output logic            rng_en,
   input  logic [INWD-1:0] rng_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            bit_out,
   output logic            last
);

   localparam int unsigned     LAST_CNT_I = usg_last_cnt(LENLOG);
   localparam logic [LENLOG-1:0] LAST_CNT = LAST_CNT_I[LENLOG-1:0];
   localparam logic [LENLOG-1:0] CNT_ONE  = LENLOG'(1);

`ifdef UNARY_STREAM_GEN_BIPOLAR_EN
   // Flipping the sign bit maps two's complement onto offset binary.
   localparam logic [INWD-1:0] MSB_FLIP = {1'b1, {(INWD-1){1'b0}}};
`else
   localparam logic [INWD-1:0] MSB_FLIP = {INWD{1'b0}};
`endif

   usg_state_t        state_r;
   usg_state_t        next_state_s;
   logic [INWD-1:0]   opnd_r;
   logic [LENLOG-1:0] cnt_r;
   logic              load_s;
   logic              xfer_s;
   logic              last_s;

   // State, operand and bit-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         opnd_r  <= {INWD{1'b0}};
         cnt_r   <= {LENLOG{1'b0}};
      end else begin
         state_r <= next_state_s;
         if (load_s) begin
            opnd_r <= in_data ^ MSB_FLIP;
            cnt_r  <= {LENLOG{1'b0}};
         end else if (xfer_s) begin
            // The counter only wraps through the final transfer.
            cnt_r <= last_s ? {LENLOG{1'b0}} : (cnt_r + CNT_ONE);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Next-state logic and handshake/stream outputs.
   always_comb begin
      next_state_s = state_r;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      rng_en       = 1'b0;
      load_s       = 1'b0;
      xfer_s       = 1'b0;
      last_s       = 1'b0;
      bit_out      = 1'b0;
      case (state_r)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_s       = 1'b1;
               next_state_s = RUN;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            out_valid = 1'b1;
            bit_out   = (rng_val < opnd_r);
            last_s    = (cnt_r == LAST_CNT);
            // RNG steps exactly when a bit is consumed; held during stalls.
            rng_en    = out_ready;
            if (out_ready) begin
               xfer_s = 1'b1;
               if (last_s) begin
                  next_state_s = IDLE;
               end else begin
                  next_state_s = RUN;
               end
            end else begin
               next_state_s = RUN;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
      last = last_s;
   end

endmodule

// File: doc/unary_stream_gen.md
Name: unary_stream_gen

Overview:
- Downstream consumer of the 4-bit dimension-1 Sobol RNG; converts a binary operand into a unipolar unary bitstream for the MAC datapath.
- Accepts one operand per valid/ready handshake and emits exactly 2^LENLOG bits, bit = (rng_val < operand).
- Drives the RNG's enable so the sequence advances only on consumed bits.
- With LENLOG = INWD the stream spans one full Sobol period, so the ones count equals the operand exactly.

Parameters:
- INWD, 4, operand and RNG value width.
- LENLOG, 4, log2 of stream length; legal range 1..INWD.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  INWD  binary operand, unsigned.
- rng_en  out  1  enable to upstream RNG; advance one step.
- rng_val  in  INWD  current RNG output (registered in RNG).
- out_valid  out  1  bit_out is valid.
- out_ready  in  1  downstream accepts bit.
- bit_out  out  1  unary stream bit.
- last  out  1  marks final bit of stream.

Behaviour:
- Reset values:
  - state=IDLE; in_ready=1 (combinational from state); out_valid=0, bit_out=0, last=0, rng_en=0.
  - Operand register and bit counter cleared.
- States: IDLE, RUN.
- IDLE:
  - in_ready=1, out_valid=0.
  - in_valid&in_ready at edge t latches in_data into opnd, clears cnt, moves to RUN.
  - First out_valid at t+1.
- RUN:
  - in_ready=0, out_valid=1.
  - bit_out = (rng_val < opnd), unsigned, combinational from registered opnd and rng_val.
  - last = (cnt == 2^LENLOG-1).
- Handshake: a bit transfers when out_valid&out_ready.
  - rng_en = RUN & out_ready, so the RNG steps exactly once per transferred bit.
  - On transfer, cnt <= cnt+1 (LENLOG-bit counter).
  - On transfer with last=1: return to IDLE and clear cnt. in_ready is high the next cycle, so there is one bubble cycle between streams.
- Backpressure: while out_ready=0, bit_out, last and cnt hold stable and rng_en=0.
- in_valid during RUN is ignored, since in_ready=0. The operand is not overwritten.
- Boundaries:
  - opnd=0 gives all zeros.
  - opnd=2^INWD-1 gives 2^LENLOG-1 ones for a full-period stream (value 1.0 is unreachable, by design).
  - cnt wraps only via the last transfer.
- RNG state is not reset between streams. Streams of length 2^INWD therefore start on a period boundary.
- rst_n assertion mid-stream:
  - Immediate return to IDLE; out_valid drops asynchronously.
  - The partial stream is discarded; no last is issued.
- out_ready low in IDLE has no effect.

Optional Feature:
- Macro: UNARY_STREAM_GEN_BIPOLAR_EN.
- Defined:
  - in_data is two's complement; the MSB is inverted on latch, so offset-binary is compared against rng_val.
  - Output is a bipolar stream: -2^(INWD-1) maps to all zeros, 0 maps to half ones.
- Undefined: in_data is unsigned, compared directly (unipolar).

Decomposition:
- Package unary_stream_pkg:
  - typedef enum logic {IDLE, RUN} usg_state_t.
  - localparam helpers for stream length (2^LENLOG) and last-count value.
- No sub-module. Comparator, counter and FSM are inline; the RNG stays a separate sibling instance wired via rng_en/rng_val.

Test Plan:
- Reset then 4-bit Sobol RNG attached, in_data=5, out_ready=1 -> out_valid 1 cycle after handshake; 16 bits with exactly 5 ones; last on 16th; in_ready high the cycle after.
- in_data=0 then in_data=15 back-to-back -> 16 zeros, then 15 ones out of 16; a single bubble cycle between streams.
- in_data=9, out_ready toggled pseudo-randomly -> bit_out/last stable while stalled; rng_en pulses exactly 16 times; 9 ones total.
- in_valid held high with in_data changing during RUN -> ignored; stream reflects latched value only.
- rst_n asserted after 7 bits of in_data=12 -> out_valid=0 immediately; in_ready=1 after release; new in_data=3 yields 3 ones in 16.
- With UNARY_STREAM_GEN_BIPOLAR_EN: in_data=-8 -> 0 ones; in_data=0 -> 8 ones; in_data=7 -> 15 ones.
